// File: rtl/game_io_pkg.sv
// Shared types and counter widths for the game I/O hub.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package game_io_pkg;

    // Snake back-buffer occupancy
    typedef enum logic {EMPTY, FULL} snake_state_t;

    // Per-player move handshake state
    typedef enum logic {IDLE, PENDING} pend_state_t;

    localparam int FRAME_CNT_W = 16;
    localparam int OVR_CNT_W   = 8;

endpackage

// File: rtl/game_io_hub_move_channel.sv
// One controller channel: synchroniser, optional debounce, sticky capture, pending handshake.
// Latency: SYNC_STAGES+1 cycles from move_in change to move_out (+DEBOUNCE_CYCLES with debounce).
// Backpressure: none; a new capture overwrites an unacked move and keeps pending high.
module move_channel
    import game_io_pkg::*;
#(
    parameter int MOVE_W          = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [MOVE_W-1:0] move_in,
    input  logic              move_ack,
    output logic [MOVE_W-1:0] move_out,
    output logic              move_pending
);

    logic [MOVE_W-1:0] sync_q [SYNC_STAGES];
    logic [MOVE_W-1:0] sync;
    logic              stable;
    logic              capture;
    pend_state_t       state, state_next;

    // Multi-flop synchroniser for the asynchronous controller word
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= move_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef GAME_IO_HUB_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [MOVE_W-1:0] last;
    logic [CNT_W-1:0]  cnt;

    // Count consecutive cycles the synchronised word has held; any change restarts at one
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last <= '0;
            cnt  <= '0;
        end else if (sync != last) begin
            last <= sync;
            cnt  <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign stable = (sync == last) && (cnt == CNT_MAX);
`else
    assign stable = 1'b1;
`endif

    // Released buttons (zero) never overwrite the last direction
    assign capture = stable && (sync != '0) && (sync != move_out);

    // Latch the captured move for the regfile
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)       move_out <= '0;
        else if (capture) move_out <= sync;
    end

    // Pending state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Capture beats a same-cycle ack; ack while idle is ignored
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (capture) state_next = PENDING;
            PENDING: if (!capture && move_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign move_pending = (state == PENDING);

endmodule

// File: rtl/game_io_hub.sv
// Move-word capture for NUM_PLAYERS controllers plus a vsync-swapped snake frame double buffer.
// Latency: moves SYNC_STAGES+1 cycles (debounce adds DEBOUNCE_CYCLES); frames swap on frame_start.
// Backpressure: none; unread frames are dropped and counted (saturating). Option: GAME_IO_HUB_DEBOUNCE_EN.
module game_io_hub
    import game_io_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int MOVE_W          = 32,
    parameter int SNAKE_W         = 456,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_PLAYERS*MOVE_W-1:0] move_in,
    input  logic [NUM_PLAYERS-1:0]        move_ack,
    output logic [NUM_PLAYERS*MOVE_W-1:0] move_out,
    output logic [NUM_PLAYERS-1:0]        move_pending,
    input  logic [SNAKE_W-1:0]            snake_in,
    input  logic                          snake_valid,
    input  logic                          frame_start,
    output logic [SNAKE_W-1:0]            snake_out,
    output logic [FRAME_CNT_W-1:0]        frame_count,
    output logic [OVR_CNT_W-1:0]          overrun_count
);

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_ch
        move_channel #(
            .MOVE_W          (MOVE_W),
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clock        (clock),
            .reset        (reset),
            .move_in      (move_in[i*MOVE_W +: MOVE_W]),
            .move_ack     (move_ack[i]),
            .move_out     (move_out[i*MOVE_W +: MOVE_W]),
            .move_pending (move_pending[i])
        );
    end

    localparam logic [OVR_CNT_W-1:0] OVR_MAX = '1;

    snake_state_t       snake_state, snake_next;
    logic [SNAKE_W-1:0] back;
    logic               swap;
    logic               drop;

    // Swap whenever vsync has something to show; any publish onto a full buffer loses a frame
    always_comb begin
        snake_next = snake_state;
        swap       = 1'b0;
        if (frame_start) begin
            snake_next = EMPTY;
            swap       = snake_valid || (snake_state == FULL);
        end else if (snake_valid) begin
            snake_next = FULL;
        end
        drop = snake_valid && (snake_state == FULL);
    end

    // Back-buffer occupancy register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) snake_state <= EMPTY;
        else        snake_state <= snake_next;
    end

    // Frame data and counters; the displayed frame only moves on a vsync cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            back          <= '0;
            snake_out     <= '0;
            frame_count   <= '0;
            overrun_count <= '0;
        end else begin
            if (snake_valid) back <= snake_in;
            if (swap) begin
                snake_out   <= snake_valid ? snake_in : back;
                frame_count <= frame_count + 1'b1;
            end
            if (drop && (overrun_count != OVR_MAX)) overrun_count <= overrun_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_game_io_hub.sv
// Bench for game_io_hub: directed vectors, behavioural model compared every cycle, literal pins.
// Latency: checks outputs on each falling edge against the model.
// Backpressure: none.
`timescale 1ns/1ps
module tb_game_io_hub;

    localparam int NP = 2;
    localparam int MW = 32;
    localparam int SW = 456;
    localparam int SS = 2;
    localparam int DC = 16;
`ifdef GAME_IO_HUB_DEBOUNCE_EN
    localparam int DB  = DC;
`else
    localparam int DB  = 0;
`endif
    localparam int LAT  = SS + DB + 1;
    localparam int HLEN = SS + DB;

    logic             clock;
    logic             reset;
    logic [NP*MW-1:0] move_in;
    logic [NP-1:0]    move_ack;
    logic [NP*MW-1:0] move_out;
    logic [NP-1:0]    move_pending;
    logic [SW-1:0]    snake_in;
    logic             snake_valid;
    logic             frame_start;
    logic [SW-1:0]    snake_out;
    logic [15:0]      frame_count;
    logic [7:0]       overrun_count;

    int passed = 0;
    int total  = 0;

    game_io_hub #(
        .NUM_PLAYERS(NP), .MOVE_W(MW), .SNAKE_W(SW), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clock(clock), .reset(reset), .move_in(move_in), .move_ack(move_ack),
        .move_out(move_out), .move_pending(move_pending), .snake_in(snake_in),
        .snake_valid(snake_valid), .frame_start(frame_start), .snake_out(snake_out),
        .frame_count(frame_count), .overrun_count(overrun_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model state: raw input history per player, captured move, pending flag, frame buffers
    logic [MW-1:0] m_hist [NP][HLEN];
    logic [MW-1:0] m_mo   [NP];
    bit            m_pend [NP];
    bit            m_full;
    logic [SW-1:0] m_back, m_out;
    int            m_fc, m_oc;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin
                for (int k = 0; k < HLEN; k++) m_hist[p][k] = '0;
                m_mo[p]   = '0;
                m_pend[p] = 0;
            end
            m_full = 0; m_back = '0; m_out = '0; m_fc = 0; m_oc = 0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                logic [MW-1:0] s;
                bit steady;
                // the synchronised word is the raw input seen SS edges ago
                s = m_hist[p][SS-1];
                steady = 1;
                for (int k = SS; k < HLEN; k++) if (m_hist[p][k] != s) steady = 0;
                if (steady && s != '0 && s != m_mo[p]) begin
                    m_mo[p]   = s;
                    m_pend[p] = 1;
                end else if (move_ack[p]) begin
                    m_pend[p] = 0;
                end
                for (int k = HLEN - 1; k > 0; k--) m_hist[p][k] = m_hist[p][k-1];
                m_hist[p][0] = move_in[p*MW +: MW];
            end
            if (snake_valid && frame_start) begin
                if (m_full && m_oc < 255) m_oc++;
                m_out  = snake_in;
                m_fc   = (m_fc + 1) % 65536;
                m_full = 0;
            end else if (snake_valid) begin
                if (m_full && m_oc < 255) m_oc++;
                m_back = snake_in;
                m_full = 1;
            end else if (frame_start && m_full) begin
                m_out  = m_back;
                m_fc   = (m_fc + 1) % 65536;
                m_full = 0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        for (int p = 0; p < NP; p++) begin
            chk("move_out", move_out[p*MW +: MW], m_mo[p]);
            chk("move_pending", move_pending[p], m_pend[p]);
        end
        chk("snake_out", snake_out, m_out);
        chk("frame_count", frame_count, m_fc[15:0]);
        chk("overrun_count", overrun_count, m_oc[7:0]);
    end

    task automatic step(input bit v, input logic [SW-1:0] d, input bit fs);
        snake_valid = v;
        snake_in    = d;
        frame_start = fs;
        @(negedge clock);
        snake_valid = 1'b0;
        frame_start = 1'b0;
        snake_in    = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0] pa, pb, pc, pd, pe;
        pa = {57{8'hA5}};
        pb = {57{8'h3C}};
        pc = {57{8'h5A}};
        pd = {57{8'h77}};
        pe = {57{8'hE1}};

        reset = 1'b0; move_in = '0; move_ack = '0;
        snake_in = '0; snake_valid = 1'b0; frame_start = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_move_out", move_out, 0);
        chk("rst_pending", move_pending, 0);
        chk("rst_snake_out", snake_out, 0);
        reset = 1'b1;

        // Move capture on player 0
        @(negedge clock);
        move_in[MW-1:0] = 32'h1;
        repeat (LAT - 1) @(negedge clock);
        chk("cap_early", move_out[MW-1:0], 0);
        @(negedge clock);
        chk("cap_p0", move_out[MW-1:0], 1);
        chk("cap_pending", move_pending, 2'b01);
        chk("p1_idle", move_out[2*MW-1:MW], 0);

        // Release is sticky, then capture together with ack
        move_in[MW-1:0] = '0;
        repeat (LAT + 3) @(negedge clock);
        chk("sticky", move_out[MW-1:0], 1);
        chk("sticky_pend", move_pending[0], 1);
        move_in[MW-1:0] = 32'h4;
        repeat (LAT - 1) @(negedge clock);
        move_ack[0] = 1'b1;
        @(negedge clock);
        move_ack[0] = 1'b0;
        chk("cap_ack_same", move_out[MW-1:0], 4);
        chk("cap_ack_pend", move_pending[0], 1);
        move_ack[0] = 1'b1;
        @(negedge clock);
        move_ack[0] = 1'b0;
        chk("ack_clears", move_pending[0], 0);

        // Frame swap
        step(1, pa, 0);
        repeat (4) @(negedge clock);
        step(0, '0, 1);
        chk("swap_a", snake_out, pa);
        chk("swap_fc", frame_count, 1);
        step(0, '0, 1);
        chk("noswap_a", snake_out, pa);
        chk("noswap_fc", frame_count, 1);

        // Overrun and bypass
        step(1, pb, 0);
        step(1, pc, 0);
        step(0, '0, 1);
        chk("ovr_c", snake_out, pc);
        chk("ovr_1", overrun_count, 1);
        step(1, pd, 0);
        step(1, pe, 1);
        chk("byp_e", snake_out, pe);
        chk("byp_ovr", overrun_count, 2);
        chk("byp_fc", frame_count, 3);

        // Overrun saturation
        for (int i = 0; i < 300; i++) step(1, SW'(i + 1), 0);
        chk("ovr_sat", overrun_count, 255);
        chk("sat_fc", frame_count, 3);

`ifdef GAME_IO_HUB_DEBOUNCE_EN
        // Glitch rejected, steady value captured after the window
        move_in[2*MW-1:MW] = 32'h2;
        repeat (10) @(negedge clock);
        move_in[2*MW-1:MW] = '0;
        repeat (30) @(negedge clock);
        chk("deb_glitch", move_out[2*MW-1:MW], 0);
        move_in[2*MW-1:MW] = 32'h2;
        repeat (18) @(negedge clock);
        chk("deb_early", move_out[2*MW-1:MW], 0);
        @(negedge clock);
        chk("deb_cap", move_out[2*MW-1:MW], 2);
`endif

        // Asynchronous reset mid-frame and mid-handshake
        step(1, pa, 0);
        move_in[MW-1:0] = 32'h8;
        repeat (LAT + 1) @(negedge clock);
        chk("pre_rst_pend", move_pending[0], 1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("arst_move_out", move_out, 0);
        chk("arst_pending", move_pending, 0);
        chk("arst_snake", snake_out, 0);
        chk("arst_fc", frame_count, 0);
        chk("arst_ovr", overrun_count, 0);
        move_in = '0;
        @(negedge clock);
        reset = 1'b1;
        step(0, '0, 1);
        chk("post_rst_fs", snake_out, 0);
        chk("post_rst_fc", frame_count, 0);

        // Frame counter wrap
        for (int i = 0; i < 65535; i++) step(1, SW'(i), 1);
        chk("fc_ffff", frame_count, 16'hFFFF);
        step(1, pb, 1);
        chk("fc_wrap", frame_count, 0);
        chk("fc_wrap_out", snake_out, pb);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/game_io_hub.md
Name: game_io_hub

Overview:
- Parametrised successor to the single-player move / fixed snake-data plumbing between the processor, regfile and VGA.
- Synchronises NUM_PLAYERS controller move words and latches each into a regfile-visible register with a pending/ack handshake.
- Double-buffers the processor-published snake frame so the VGA side only sees whole frames, swapped on vsync.
- Sits between the board inputs/processor and the regfile/VGA, inside the top-level processor wrapper.

Parameters:
- NUM_PLAYERS, 2: number of controller channels.
- MOVE_W, 32: width of one move word.
- SNAKE_W, 456: width of the snake frame vector.
- SYNC_STAGES, 2: synchroniser depth per move channel; must be at least 2.
- DEBOUNCE_CYCLES, 16: stability window, used only with the debounce feature.

Ports:
- clock  in  1  system clock; all flops rising-edge.
- reset  in  1  asynchronous, active-low reset.
- move_in  in  NUM_PLAYERS*MOVE_W  raw, asynchronous controller words; player i occupies bits [i*MOVE_W +: MOVE_W].
- move_ack  in  NUM_PLAYERS  processor clears pending[i].
- move_out  out  NUM_PLAYERS*MOVE_W  latched moves to the regfile.
- move_pending  out  NUM_PLAYERS  a new move has been latched and not yet acked.
- snake_in  in  SNAKE_W  frame from the processor.
- snake_valid  in  1  one-cycle publish strobe.
- frame_start  in  1  one-cycle vsync pulse from the VGA domain, already synchronous to clock.
- snake_out  out  SNAKE_W  frame currently displayed.
- frame_count  out  16  number of swaps performed; wraps.
- overrun_count  out  8  published frames dropped before display; saturates at 255.

Behaviour:
- Reset (reset=0, asynchronous):
  - move_out, move_pending, snake_out, frame_count, overrun_count, synchronisers and back buffer all go to 0.
  - Back-buffer state returns to EMPTY.
- Move path, per channel i:
  - move_in passes through SYNC_STAGES flops to give sync_i.
  - A value is a candidate when sync_i is non-zero and differs from move_out[i].
  - On a candidate, move_out[i] <= sync_i and pending[i] <= 1. Latency from a move_in change to move_out is SYNC_STAGES+1 cycles.
  - A zero sync_i (button released) never updates move_out, so the last direction is sticky.
- Per-channel pending FSM:
  - IDLE -> PENDING on capture.
  - PENDING -> IDLE on move_ack[i].
  - Capture and ack in the same cycle: the capture wins; pending stays 1 and move_out takes the new value.
  - A new capture while already PENDING overwrites move_out and keeps pending at 1. No overrun is counted on the move path.
  - Ack while IDLE is ignored.
- Snake path FSM, state EMPTY or FULL:
  - snake_valid only: back <= snake_in; go to FULL. If already FULL, overrun_count increments (saturating).
  - frame_start only, FULL: snake_out <= back, frame_count++, go to EMPTY.
  - frame_start only, EMPTY: no change; snake_out holds the previous frame.
  - Both in the same cycle: snake_out <= snake_in (bypass, newest wins), frame_count++, state EMPTY. If the state was FULL, the stale back buffer is discarded and overrun_count increments.
  - snake_out changes only on a cycle where frame_start=1, so it never tears.
- Arithmetic:
  - frame_count wraps 0xFFFF -> 0.
  - overrun_count holds at 0xFF.
- Reset asserted mid-frame or mid-handshake: everything clears immediately; the first frame_start after reset leaves snake_out at 0 unless snake_valid is asserted.

Optional Feature:
- Macro: GAME_IO_HUB_DEBOUNCE_EN.
- Defined:
  - Each channel has a stability counter of width clog2(DEBOUNCE_CYCLES+1).
  - sync_i becomes a candidate only after it has held the same value for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
  - Capture latency is SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles.
- Undefined: no counters are instantiated; latency is as stated under Behaviour.

Decomposition:
- Shared package game_io_pkg holds:
  - snake FSM state typedef (EMPTY, FULL);
  - pending FSM typedef (IDLE, PENDING);
  - FRAME_CNT_W=16 and OVR_CNT_W=8.
- Sub-module move_channel: synchroniser, optional debounce, capture logic and pending FSM for one player. It is instantiated NUM_PLAYERS times in a generate loop.
- The snake double buffer stays in the top level.

Test Plan:
- Move capture: reset, then move_in[player0]=32'h1 -> after 3 cycles move_out[0]=1 and pending[0]=1. Player 1 outputs stay 0.
- Sticky direction and simultaneous events: move_in goes 1 -> 0 -> move_out stays 1. Then present 4 with move_ack[0]=1 in the capture cycle -> move_out=4 and pending stays 1. A following ack alone -> pending=0.
- Frame swap: snake_valid with A, then frame_start 5 cycles later -> snake_out=A, frame_count=1. A second frame_start with no publish -> snake_out stays A, frame_count stays 1.
- Overrun and bypass:
  - Publish B, then C, then frame_start -> snake_out=C, overrun_count=1.
  - Then publish D and assert snake_valid=E together with frame_start -> snake_out=E, overrun_count=2, frame_count increments.
- Saturation, wrap and reset:
  - 300 publishes with no frame_start -> overrun_count=255.
  - Force 65536 swaps -> frame_count=0.
  - Assert reset mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.
- Debounce (GAME_IO_HUB_DEBOUNCE_EN defined, DEBOUNCE_CYCLES=16):
  - A 10-cycle glitch to 2 -> no capture.
  - A steady 2 -> captured exactly 2+16+1=19 cycles after the move_in change.
